multiword_add_sequencer: RTL and testbench
==========================================

# multiword_add_sequencer

- Feeds the team's 4-bit ripple carry adder stage, which sits directly downstream.
- Accepts two `4*WORDS`-bit operands over a valid/ready handshake.
- Presents them to the external 4-bit adder one nibble per cycle, least-significant first, chaining the carry through a register.
- Returns the full-width sum and final carry over a second valid/ready handshake, so narrow combinational adder hardware can serve wide additions.

## Interface
- `WORDS`, default 4: number of 4-bit slices. Operand width is `W = 4*WORDS`. Minimum 1.
- `clk` input 1: sole clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `in_valid` input 1: operand request valid.
- `in_ready` output 1: block can accept a request.
- `in_a` input W: operand A.
- `in_b` input W: operand B.
- `in_cin` input 1: carry into slice 0.
- `in_sub` input 1: subtract request. Present only with `SEQ_ADD_SUB_EN`.
- `add_a` output 4: A slice to the adder.
- `add_b` output 4: B slice to the adder.
- `add_cin` output 1: carry to the adder.
- `add_sum` input 4: adder sum, combinational return.
- `add_cout` input 1: adder carry out, combinational return.
- `out_valid` output 1: result valid.
- `out_ready` input 1: consumer accepts the result.
- `out_sum` output W: full sum.
- `out_cout` output 1: carry out of the top slice.

## Operation
- **FSM states:** IDLE, RUN, DONE.
- **Reset values:** state IDLE, `in_ready`=1, `out_valid`=0, `out_sum`=0, `out_cout`=0, `add_a`/`add_b`/`add_cin`=0, slice index=0, carry register=0.
- **IDLE:**
  - `in_ready`=1.
  - On `in_valid && in_ready` at an edge: latch `in_a`, `in_b` and `in_cin` into the carry register; clear the result register; index=0; go to RUN.
- **RUN:**
  - `in_ready`=0.
  - `add_a` = A[4k+3:4k], `add_b` = B[4k+3:4k], `add_cin` = carry register, where k = index.
  - Each edge: write `add_sum` into result[4k+3:4k], load `add_cout` into the carry register, increment index.
  - On the edge where k = WORDS-1: write the final slice; `out_cout` ← `add_cout`; go to DONE.
- **DONE:**
  - `out_valid`=1, `in_ready`=0.
  - `out_sum` and `out_cout` held stable until `out_valid && out_ready` at an edge; then go to IDLE.
- **Adder drive outside RUN:** `add_a`, `add_b` and `add_cin` are driven to 0 in IDLE and DONE.
- **Width rules:**
  - Result is the unsigned `(W+1)`-bit sum `{out_cout, out_sum}` = A + B + cin.
  - No overflow flag.
- **Boundary conditions:**
  - `in_valid` during RUN or DONE is ignored; the operands are not latched.
  - `rst` mid-RUN or mid-DONE aborts the operation: result discarded, all outputs return to their reset values the next cycle.
  - No accept in the same cycle as the result handshake; `in_ready` rises the cycle after DONE exits.
  - `WORDS`=1: RUN lasts exactly one cycle.

## Timing
- Accept edge E0. Slice k is presented during the cycle after edge Ek. Its result is captured at edge E(k+1).
- `out_valid` is high from edge E_WORDS onward. Latency from accept to `out_valid` is WORDS cycles. With WORDS=4 that is 4 cycles.
- Throughput is at most one operation per WORDS+2 cycles with `out_ready` held high.
- The adder path is combinational within one cycle. The block adds no adder-side register.
- `out_sum` and `out_cout` are registered and change only on the edge into DONE or on reset.

## Configuration
- **Macro:** `SEQ_ADD_SUB_EN`.
- **Defined:**
  - `in_sub` port exists and is latched at accept.
  - When `in_sub`=1, B is stored bit-inverted and the carry register is loaded with 1, regardless of `in_cin`.
  - Result = A − B modulo 2^W. `out_cout`=1 means no borrow.
- **Undefined:** `in_sub` is absent. Behaviour is pure addition with `in_cin`.

## Test plan
- WORDS=4. Accept A=0x0002, B=0x0003, cin=0 → after 4 cycles `out_valid`=1, `out_sum`=0x0005, `out_cout`=0. Check `add_a`/`add_b` per cycle: 2/3, 0/0, 0/0, 0/0.
- A=0xFFFF, B=0x0001, cin=0 → `add_cin` sequence 0,1,1,1; `out_sum`=0x0000, `out_cout`=1.
- A=0x0F0F, B=0x00F1, cin=1 → `out_sum`=0x1001, `out_cout`=0.
- Backpressure:
  - Stimulus: hold `out_ready`=0 for 5 cycles in DONE while pulsing `in_valid` with new operands.
  - Required: `out_sum` is stable, `in_ready`=0, new operands are not latched, `in_ready`=1 the cycle after the handshake.
- Assert `rst` during the 2nd RUN cycle → next cycle state IDLE, `in_ready`=1, `out_valid`=0, `add_*`=0, `out_sum`=0. A subsequent 0x0002+0x0003 yields 0x0005.
- With `SEQ_ADD_SUB_EN`: A=0x0005, B=0x0007, `in_sub`=1 → `out_sum`=0xFFFE, `out_cout`=0. A=0x0007, B=0x0005 → 0x0002, `out_cout`=1.

Source files
------------

// File: rtl/multiword_add_sequencer.sv
// multiword_add_sequencer
//
// Purpose: serialises a wide addition onto a narrow 4-bit combinational adder
// that sits directly downstream. Two W-bit operands (W = 4*WORDS) are accepted
// over a valid/ready handshake. One nibble per cycle is presented to the
// external adder, least-significant first, with the carry chained through a
// register. The full sum and final carry are returned over a second
// valid/ready handshake.
//
// Optional feature: define SEQ_ADD_SUB_EN to add the in_sub port. When in_sub
// is set at accept, B is stored inverted and the carry register is seeded with
// 1, so the result is A - B modulo 2^W and out_cout = 1 means "no borrow".
//
// Ports:
//   clk, rst          clock (rising edge), synchronous active-high reset
//   in_valid/in_ready request handshake
//   in_a, in_b        W-bit operands
//   in_cin            carry into slice 0
//   in_sub            subtract request (only with SEQ_ADD_SUB_EN)
//   add_a/add_b       4-bit slices driven to the external adder (0 outside RUN)
//   add_cin           carry driven to the external adder (0 outside RUN)
//   add_sum/add_cout  combinational return from the external adder
//   out_valid/out_ready result handshake
//   out_sum, out_cout registered W-bit sum and carry out of the top slice

module multiword_add_sequencer #(
    parameter int WORDS = 4,
    localparam int W = 4 * WORDS
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    input  logic         in_cin,
`ifdef SEQ_ADD_SUB_EN
    input  logic         in_sub,
`endif
    output logic [3:0]   add_a,
    output logic [3:0]   add_b,
    output logic         add_cin,
    input  logic [3:0]   add_sum,
    input  logic         add_cout,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_sum,
    output logic         out_cout
);

    // Slice index needs at least one bit even when there is a single slice.
    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             carry_q, carry_d;
    logic [W-1:0]     a_q, a_d;
    logic [W-1:0]     b_q, b_d;
    logic [W-1:0]     res_q, res_d;
    logic [W-1:0]     out_sum_q, out_sum_d;
    logic             out_cout_q, out_cout_d;

    // State and datapath registers. Reset discards any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            carry_q    <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            res_q      <= '0;
            out_sum_q  <= '0;
            out_cout_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            carry_q    <= carry_d;
            a_q        <= a_d;
            b_q        <= b_d;
            res_q      <= res_d;
            out_sum_q  <= out_sum_d;
            out_cout_q <= out_cout_d;
        end
    end

    // Next-state and output logic. The adder path is purely combinational:
    // the current slice leaves via add_a/add_b/add_cin and its sum comes back
    // within the same cycle to be captured at the next edge.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        carry_d    = carry_q;
        a_d        = a_q;
        b_d        = b_q;
        res_d      = res_q;
        out_sum_d  = out_sum_q;
        out_cout_d = out_cout_q;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        add_a      = 4'h0;
        add_b      = 4'h0;
        add_cin    = 1'b0;

        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    a_d     = in_a;
                    b_d     = in_b;
                    carry_d = in_cin;
`ifdef SEQ_ADD_SUB_EN
                    // Two's-complement subtract: A + ~B + 1.
                    if (in_sub) begin
                        b_d     = ~in_b;
                        carry_d = 1'b1;
                    end
`endif
                    res_d   = '0;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end

            RUN: begin
                add_a   = a_q[{idx_q, 2'b00} +: 4];
                add_b   = b_q[{idx_q, 2'b00} +: 4];
                add_cin = carry_q;
                res_d[{idx_q, 2'b00} +: 4] = add_sum;
                carry_d = add_cout;
                if (idx_q == LAST_IDX) begin
                    // res_d already holds the top slice, so the visible
                    // result only ever changes on the edge into DONE.
                    out_sum_d  = res_d;
                    out_cout_d = add_cout;
                    idx_d      = '0;
                    state_d    = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end

            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign out_sum  = out_sum_q;
    assign out_cout = out_cout_q;

endmodule

// File: tb/tb_multiword_add_sequencer.sv
// tb_multiword_add_sequencer
//
// Purpose: self-checking bench for multiword_add_sequencer with WORDS=4.
// Models the downstream 4-bit adder, drives directed and random operations,
// and compares results through a scoreboard queue popped by a monitor on each
// result handshake. Expected values come from whole-word arithmetic.

module tb_multiword_add_sequencer;

    localparam int WORDS = 4;
    localparam int W     = 4 * WORDS;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_cin;
    logic         in_sub;
    logic [3:0]   add_a;
    logic [3:0]   add_b;
    logic         add_cin;
    logic [3:0]   add_sum;
    logic         add_cout;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
    logic         out_cout;

    int vectors     = 0;
    int miscompares = 0;

    logic [W:0] expQ[$];
    logic [W:0] lastExp;
    logic [W:0] monExp;

    multiword_add_sequencer #(.WORDS(WORDS)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_a     (in_a),
        .in_b     (in_b),
        .in_cin   (in_cin),
`ifdef SEQ_ADD_SUB_EN
        .in_sub   (in_sub),
`endif
        .add_a    (add_a),
        .add_b    (add_b),
        .add_cin  (add_cin),
        .add_sum  (add_sum),
        .add_cout (add_cout),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_sum  (out_sum),
        .out_cout (out_cout)
    );

    // The external 4-bit ripple carry adder stage.
    logic [4:0] adderFull;
    assign adderFull = {1'b0, add_a} + {1'b0, add_b} + {4'b0, add_cin};
    assign add_sum   = adderFull[3:0];
    assign add_cout  = adderFull[4];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Global time limit so the bench can never hang.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Whole-word reference: unsigned (W+1)-bit sum, or A-B with no-borrow flag.
    function automatic logic [W:0] refResult(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic cin, input logic sub);
        logic [W:0] r;
        if (sub) begin
            r[W-1:0] = a - b;
            r[W]     = (a >= b);
        end else begin
            r = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
        end
        return r;
    endfunction

    // Carry entering slice k: carry out of the low 4k bits of the addition.
    function automatic logic refCarryIn(input logic [W-1:0] a, input logic [W-1:0] bEff,
                                        input logic cinEff, input int k);
        longint unsigned mask, total, av, bv;
        if (k == 0) return cinEff;
        av    = a;
        bv    = bEff;
        mask  = (64'd1 << (4 * k)) - 64'd1;
        total = (av & mask) + (bv & mask) + {63'd0, cinEff};
        return ((total >> (4 * k)) & 64'd1) != 64'd0;
    endfunction

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Accepts one operation, then follows it slice by slice while throwing
    // junk requests at the busy block.
    task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic cin, input logic sub);
        int waitCycles = 0;
        logic [W-1:0] bEff;
        logic cinEff;
        while (!in_ready && waitCycles < 50) begin
            @(posedge clk); #1;
            waitCycles++;
        end
        if (!in_ready) begin
            check("accept_timeout", {31'd0, in_ready}, 32'd1);
            return;
        end
        bEff    = sub ? ~b : b;
        cinEff  = sub ? 1'b1 : cin;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_cin   = cin;
        in_sub   = sub;
        lastExp  = refResult(a, b, cin, sub);
        expQ.push_back(lastExp);
        @(posedge clk); #1;
        for (int k = 0; k < WORDS; k++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_a     = W'($urandom);
            in_b     = W'($urandom);
            in_cin   = 1'($urandom_range(0, 1));
            in_sub   = 1'($urandom_range(0, 1));
            check("run_add_a",   {28'd0, add_a},   {28'd0, a[4*k +: 4]});
            check("run_add_b",   {28'd0, add_b},   {28'd0, bEff[4*k +: 4]});
            check("run_add_cin", {31'd0, add_cin}, {31'd0, refCarryIn(a, bEff, cinEff, k)});
            check("run_in_ready", {31'd0, in_ready}, 32'd0);
            check("run_out_valid", {31'd0, out_valid}, 32'd0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check("done_out_valid", {31'd0, out_valid}, 32'd1);
    endtask

    // Holds the result under backpressure for holdCycles, then completes the
    // result handshake and checks that the block is ready again.
    task automatic checkOutput(input int holdCycles);
        for (int i = 0; i < holdCycles; i++) begin
            out_ready = 1'b0;
            in_valid  = 1'($urandom_range(0, 1));
            in_a      = W'($urandom);
            in_b      = W'($urandom);
            check("hold_out_sum",   {{(32-W){1'b0}}, out_sum}, {{(32-W){1'b0}}, lastExp[W-1:0]});
            check("hold_out_cout",  {31'd0, out_cout}, {31'd0, lastExp[W]});
            check("hold_in_ready",  {31'd0, in_ready}, 32'd0);
            check("hold_out_valid", {31'd0, out_valid}, 32'd1);
            check("hold_add_a",     {28'd0, add_a}, 32'd0);
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("post_in_ready",  {31'd0, in_ready}, 32'd1);
        check("post_out_valid", {31'd0, out_valid}, 32'd0);
    endtask

    // Scoreboard monitor: pops one expectation per result handshake.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (expQ.size() == 0) begin
                vectors++;
                miscompares++;
                $display("[TB] FAIL unexpected_result: got 0x%0h with empty scoreboard", out_sum);
            end else begin
                monExp = expQ.pop_front();
                check("result_sum",  {{(32-W){1'b0}}, out_sum}, {{(32-W){1'b0}}, monExp[W-1:0]});
                check("result_cout", {31'd0, out_cout}, {31'd0, monExp[W]});
            end
        end
    end

    initial begin
        logic [W-1:0] ra, rb;
        logic rc, rs;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_cin    = 1'b0;
        in_sub    = 1'b0;
        out_ready = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("reset_in_ready",  {31'd0, in_ready}, 32'd1);
        check("reset_out_valid", {31'd0, out_valid}, 32'd0);
        check("reset_out_sum",   {{(32-W){1'b0}}, out_sum}, 32'd0);
        check("reset_out_cout",  {31'd0, out_cout}, 32'd0);
        check("reset_add",       {23'd0, add_a, add_b, add_cin}, 32'd0);
        rst = 1'b0;

        applyStimulus(16'h0002, 16'h0003, 1'b0, 1'b0);
        checkOutput(0);
        applyStimulus(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        checkOutput(1);
        applyStimulus(16'h0F0F, 16'h00F1, 1'b1, 1'b0);
        checkOutput(5);

        // Abort an operation with reset during its second RUN cycle.
        in_valid = 1'b1;
        in_a     = 16'h1234;
        in_b     = 16'h4321;
        in_cin   = 1'b1;
        in_sub   = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_in_ready",  {31'd0, in_ready}, 32'd1);
        check("abort_out_valid", {31'd0, out_valid}, 32'd0);
        check("abort_add",       {23'd0, add_a, add_b, add_cin}, 32'd0);
        check("abort_out_sum",   {{(32-W){1'b0}}, out_sum}, 32'd0);
        check("abort_out_cout",  {31'd0, out_cout}, 32'd0);
        applyStimulus(16'h0002, 16'h0003, 1'b0, 1'b0);
        checkOutput(0);

`ifdef SEQ_ADD_SUB_EN
        applyStimulus(16'h0005, 16'h0007, 1'b0, 1'b1);
        checkOutput(1);
        applyStimulus(16'h0007, 16'h0005, 1'b1, 1'b1);
        checkOutput(0);
`endif

        for (int n = 0; n < 20; n++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom_range(0, 1));
`ifdef SEQ_ADD_SUB_EN
            rs = 1'($urandom_range(0, 1));
`else
            rs = 1'b0;
`endif
            applyStimulus(ra, rb, rc, rs);
            checkOutput(int'($urandom_range(0, 3)));
        end

        @(posedge clk); #1;
        check("scoreboard_empty", expQ.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
